ddr_rd_arbiter: RTL and testbench

- Sits directly upstream of the Q/K/V/MLP weight FIFO stages and arbitrates their DDR read-burst requests onto the single DDR read master.
- Round-robin grant, one burst at a time; the burst address and length are captured at grant.
- Read data, valid and finish are routed back so that only the granted requester observes its burst.
- Also provides a beat-count integrity check for bring-up.

---
 rtl/ddr_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: round-robin arbiter that gives one of NUM_PORTS weight-FIFO
// requesters at a time the single DDR read master. The burst address and length
// are captured at grant. Read data, valid and finish are steered back so that
// only the owner of the burst sees them.
//
// Handshake: a requester holds i_rd_burst_req as a level until it sees its
// o_rd_burst_finish bit. It then drops the request on the following edge. The
// DDR master sees m_rd_burst_req high for the whole burst. It returns beats on
// m_rd_burst_valid and ends the burst with a single-cycle m_rd_burst_finish.
// After each finish, IDLE ignores requests for one cycle. This guard cycle keeps
// a request that has not yet been withdrawn from being granted again.
module ddr_rd_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_SIZE  = 32,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic [NUM_PORTS-1:0]           i_rd_burst_req,
  input  logic [NUM_PORTS*ADDR_SIZE-1:0] i_rd_burst_addr,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0] i_rd_burst_len,
  output logic [DATA_WIDTH-1:0]          o_rd_burst_data,
  output logic [NUM_PORTS-1:0]           o_rd_burst_valid,
  output logic [NUM_PORTS-1:0]           o_rd_burst_finish,
  output logic                           m_rd_burst_req,
  output logic [ADDR_SIZE-1:0]           m_rd_burst_addr,
  output logic [LEN_WIDTH-1:0]           m_rd_burst_len,
  input  logic [DATA_WIDTH-1:0]          m_rd_burst_data,
  input  logic                           m_rd_burst_valid,
  input  logic                           m_rd_burst_finish,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic                           o_busy,
  output logic                           o_len_err,
  output logic                           fsm_state
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = LEN_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, grant_idx;
  logic [PTR_W-1:0]   sel_idx, hi_idx, lo_idx;
  logic               sel_found, hi_found, lo_found;
  logic               guard;
  logic               start, done;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;

  // The state is exposed for checkers and debug. 0 = IDLE, 1 = BURST.
  assign fsm_state = state;

  // Steer the return path to the owner. o_grant is zero in IDLE, so stray
  // beats or finish pulses there reach no port.
  assign o_rd_burst_data   = m_rd_burst_data;
  assign o_rd_burst_valid  = o_grant & {NUM_PORTS{m_rd_burst_valid}};
  assign o_rd_burst_finish = o_grant & {NUM_PORTS{m_rd_burst_finish}};

  // Round-robin pick: hi_* is the first request at or above rr_ptr, and lo_*
  // is the first request from index 0, used when the search wraps.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (i_rd_burst_req[j]) begin
        lo_found = 1'b1;
        lo_idx   = PTR_W'(j);
        if (j >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(j);
        end
      end
    end
    sel_found = lo_found;
    sel_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Beat count including any beat on this cycle. It saturates rather than wraps,
  // so an overlong burst can never alias back to a matching count.
  always_comb begin
    beat_cnt_nxt = beat_cnt;
    if (m_rd_burst_valid && (beat_cnt != {CNT_W{1'b1}}))
      beat_cnt_nxt = beat_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the start/done strobes that drive the datapath.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (!guard && sel_found) begin
          start     = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (m_rd_burst_finish) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. This block captures the grant and burst parameters, counts beats,
  // and on finish advances the pointer and records any beat-count mismatch.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      m_rd_burst_req  <= 1'b0;
      m_rd_burst_addr <= '0;
      m_rd_burst_len  <= '0;
      o_grant         <= '0;
      o_busy          <= 1'b0;
      o_len_err       <= 1'b0;
      rr_ptr          <= '0;
      grant_idx       <= '0;
      beat_cnt        <= '0;
      guard           <= 1'b0;
    end else begin
      guard <= done;
      if (start) begin
        o_grant         <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << sel_idx;
        grant_idx       <= sel_idx;
        m_rd_burst_addr <= i_rd_burst_addr[sel_idx*ADDR_SIZE +: ADDR_SIZE];
        m_rd_burst_len  <= i_rd_burst_len[sel_idx*LEN_WIDTH +: LEN_WIDTH];
        m_rd_burst_req  <= 1'b1;
        o_busy          <= 1'b1;
        beat_cnt        <= '0;
      end
      if (state == BURST)
        beat_cnt <= beat_cnt_nxt;
      if (done) begin
        m_rd_burst_req <= 1'b0;
        o_busy         <= 1'b0;
        o_grant        <= '0;
        rr_ptr         <= (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        if (beat_cnt_nxt != {1'b0, m_rd_burst_len})
          o_len_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed bench for ddr_rd_arbiter. The bench plays both
// roles: the requesters and a simple DDR master model. Inputs change on the
// falling edge and outputs are checked there, or 1 ns later for the
// combinational return path.
module tb_ddr_rd_arbiter;

  logic         s_clk;
  logic         s_rst;
  logic [3:0]   req;
  logic [127:0] addr_bus;
  logic [39:0]  len_bus;
  logic [63:0]  o_data;
  logic [3:0]   o_valid;
  logic [3:0]   o_finish;
  logic         m_req;
  logic [31:0]  m_addr;
  logic [9:0]   m_len;
  logic [63:0]  m_data;
  logic         m_valid;
  logic         m_finish;
  logic [3:0]   grant;
  logic         busy;
  logic         len_err;
  logic         fsm_state;

  int n_chk;
  int n_bad;

  ddr_rd_arbiter dut (
    .s_clk             (s_clk),
    .s_rst             (s_rst),
    .i_rd_burst_req    (req),
    .i_rd_burst_addr   (addr_bus),
    .i_rd_burst_len    (len_bus),
    .o_rd_burst_data   (o_data),
    .o_rd_burst_valid  (o_valid),
    .o_rd_burst_finish (o_finish),
    .m_rd_burst_req    (m_req),
    .m_rd_burst_addr   (m_addr),
    .m_rd_burst_len    (m_len),
    .m_rd_burst_data   (m_data),
    .m_rd_burst_valid  (m_valid),
    .m_rd_burst_finish (m_finish),
    .o_grant           (grant),
    .o_busy            (busy),
    .o_len_err         (len_err),
    .fsm_state         (fsm_state)
  );

  // Clock and watchdog.
  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // The single comparison point. Every check in the bench goes through here.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return one << p;
  endfunction

  // Driver: load one requester's address and length.
  task automatic set_port(input int p, input logic [31:0] a, input logic [9:0] l);
    addr_bus[p*32 +: 32] = a;
    len_bus[p*10 +: 10]  = l;
  endtask

  // Driver: assert reset for one cycle and check the reset values.
  task automatic do_reset();
    @(negedge s_clk);
    s_rst = 1'b1;
    @(negedge s_clk);
    check("rst_m_req",   64'(m_req),     64'(0));
    check("rst_m_addr",  64'(m_addr),    64'(0));
    check("rst_m_len",   64'(m_len),     64'(0));
    check("rst_grant",   64'(grant),     64'(0));
    check("rst_busy",    64'(busy),      64'(0));
    check("rst_len_err", 64'(len_err),   64'(0));
    check("rst_state",   64'(fsm_state), 64'(0));
    s_rst = 1'b0;
  endtask

  // Wait for the master request to rise and check the gap in falling edges.
  // A request raised while IDLE with no guard gives 1. A request right after a
  // finish gives 2.
  task automatic wait_req(input int exp_wait);
    int w;
    w = 0;
    while (!m_req && w < 50) begin
      @(negedge s_clk);
      w++;
    end
    check("req_seen", 64'(m_req), 64'(1));
    if (exp_wait > 0) check("req_gap", 64'(w), 64'(exp_wait));
  endtask

  // DDR model plus requester actions for one burst. act_kind 1 changes port p's
  // address to act_val before beat act_beat. act_kind 2 drops port p's request
  // there instead.
  task automatic run_burst(input int p, input logic [31:0] ea, input logic [9:0] el,
                           input int nbeats, input int exp_wait,
                           input int act_beat, input int act_kind, input logic [31:0] act_val);
    wait_req(exp_wait);
    check("grant",  64'(grant),     64'(onehot(p)));
    check("m_addr", 64'(m_addr),    64'(ea));
    check("m_len",  64'(m_len),     64'(el));
    check("busy",   64'(busy),      64'(1));
    check("state",  64'(fsm_state), 64'(1));
    for (int b = 0; b < nbeats; b++) begin
      if (b == act_beat && act_kind == 1) addr_bus[p*32 +: 32] = act_val;
      if (b == act_beat && act_kind == 2) req[p] = 1'b0;
      m_valid = 1'b1;
      m_data  = {32'(p + 1), ea ^ 32'(b)};
      #1;
      check("beat_valid", 64'(o_valid), 64'(onehot(p)));
      check("beat_data",  o_data, {32'(p + 1), ea ^ 32'(b)});
      @(negedge s_clk);
    end
    m_valid  = 1'b0;
    m_finish = 1'b1;
    #1;
    check("finish_out",  64'(o_finish), 64'(onehot(p)));
    check("finish_addr", 64'(m_addr),   64'(ea));
    @(negedge s_clk);
    m_finish = 1'b0;
    check("end_m_req", 64'(m_req),     64'(0));
    check("end_grant", 64'(grant),     64'(0));
    check("end_busy",  64'(busy),      64'(0));
    check("end_state", 64'(fsm_state), 64'(0));
  endtask

  // Directed sequence.
  initial begin
    n_chk    = 0;
    n_bad    = 0;
    s_rst    = 1'b1;
    req      = '0;
    addr_bus = '0;
    len_bus  = '0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_finish = 1'b0;
    repeat (2) @(negedge s_clk);
    check("por_m_req", 64'(m_req),   64'(0));
    check("por_grant", 64'(grant),   64'(0));
    check("por_busy",  64'(busy),    64'(0));
    check("por_err",   64'(len_err), 64'(0));
    s_rst = 1'b0;

    // Single request on port 2.
    set_port(2, 32'h0010_0000, 10'd32);
    req[2] = 1'b1;
    run_burst(2, 32'h0010_0000, 10'd32, 32, 1, -1, 0, 32'h0);
    req[2] = 1'b0;
    check("single_len_err", 64'(len_err), 64'(0));

    // Stray beat and finish while IDLE: no port sees them, and the error flag
    // does not change.
    @(negedge s_clk);
    m_valid  = 1'b1;
    m_finish = 1'b1;
    #1;
    check("idle_valid",  64'(o_valid),  64'(0));
    check("idle_finish", 64'(o_finish), 64'(0));
    @(negedge s_clk);
    m_valid  = 1'b0;
    m_finish = 1'b0;
    check("idle_err",   64'(len_err), 64'(0));
    check("idle_grant", 64'(grant),   64'(0));

    // All four ports request continuously from reset: the order is 0,1,2,3,0,1.
    do_reset();
    for (int p = 0; p < 4; p++) set_port(p, 32'h1000 * (p + 1), 10'd4);
    req = 4'hf;
    for (int k = 0; k < 6; k++)
      run_burst(k % 4, 32'h1000 * ((k % 4) + 1), 10'd4, 4, (k == 0) ? 1 : 2, -1, 0, 32'h0);
    req = '0;

    // Port 1 changes its address mid-burst. The change is ignored until the next
    // grant.
    set_port(1, 32'h2000, 10'd4);
    req[1] = 1'b1;
    run_burst(1, 32'h2000, 10'd4, 4, 2, 2, 1, 32'h3000);
    run_burst(1, 32'h3000, 10'd4, 4, 2, -1, 0, 32'h0);
    req[1] = 1'b0;

    // Beat mismatch: 31 beats against a length of 32. The flag is sticky.
    set_port(0, 32'h4000, 10'd32);
    req[0] = 1'b1;
    run_burst(0, 32'h4000, 10'd32, 31, 2, -1, 0, 32'h0);
    req[0] = 1'b0;
    check("mismatch_err", 64'(len_err), 64'(1));
    set_port(1, 32'h5000, 10'd8);
    req[1] = 1'b1;
    run_burst(1, 32'h5000, 10'd8, 8, 2, -1, 0, 32'h0);
    req[1] = 1'b0;
    check("sticky_err", 64'(len_err), 64'(1));

    // Port 0 withdraws after 10 of 32 beats. The burst still completes on bit 0,
    // and then the pending port 3 is granted.
    do_reset();
    set_port(0, 32'h6000, 10'd32);
    set_port(3, 32'h7000, 10'd4);
    req = 4'b1001;
    run_burst(0, 32'h6000, 10'd32, 32, 1, 10, 2, 32'h0);
    run_burst(3, 32'h7000, 10'd4, 4, 2, -1, 0, 32'h0);
    req = '0;
    check("withdraw_err", 64'(len_err), 64'(0));

    // Async reset mid-burst. First move rr_ptr to 3, then reset during port 3's
    // burst at beat 5.
    set_port(2, 32'h8000, 10'd4);
    req[2] = 1'b1;
    run_burst(2, 32'h8000, 10'd4, 4, 2, -1, 0, 32'h0);
    req[2] = 1'b0;
    set_port(3, 32'h9000, 10'd16);
    req[3] = 1'b1;
    wait_req(2);
    check("pre_rst_grant", 64'(grant), 64'(onehot(3)));
    for (int b = 0; b < 5; b++) begin
      m_valid = 1'b1;
      m_data  = 64'(b);
      @(negedge s_clk);
    end
    m_valid = 1'b1;
    #2;
    s_rst = 1'b1;
    #1;
    check("arst_m_req",  64'(m_req),     64'(0));
    check("arst_grant",  64'(grant),     64'(0));
    check("arst_busy",   64'(busy),      64'(0));
    check("arst_valid",  64'(o_valid),   64'(0));
    check("arst_addr",   64'(m_addr),    64'(0));
    check("arst_state",  64'(fsm_state), 64'(0));
    @(negedge s_clk);
    m_valid = 1'b0;
    s_rst   = 1'b0;
    set_port(1, 32'hA000, 10'd4);
    req[1] = 1'b1;
    run_burst(1, 32'hA000, 10'd4, 4, 1, -1, 0, 32'h0);
    req = '0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
